// File: rtl/pipeline_flow_controller_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_flow_controller_pkg
// Shared definitions for the front-end flow controller: sequencer state
// encoding, default watchdog / drain parameters and the NOP encoding that the
// IF/ID register loads when it is flushed.
// -----------------------------------------------------------------------------
package pipeline_flow_controller_pkg;

   // Sequencer states: normal flow, emptying the back end, quiescent.
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } flow_state_e;

   localparam int DEF_STALL_LIMIT  = 15;
   localparam int DEF_DRAIN_CYCLES = 4;

   // Encoding that IF/ID holds after a flush (addi x0, x0, 0). Kept here so
   // the pipeline-register owners reference one definition.
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage : pipeline_flow_controller_pkg

// File: rtl/pipeline_flow_controller_stall_watchdog.sv
// -----------------------------------------------------------------------------
// stall_watchdog
// Counts consecutive cycles in which a decode stall is actually applied and
// raises a sticky flag once the run length reaches STALL_LIMIT. Any cycle
// without an applied stall restarts the count. The flag clears only on Rst.
//
// Ports:
//   Clk           in  pipeline clock, rising edge
//   Rst           in  asynchronous active-high reset
//   stall_applied in  decode-stall case taken this cycle
//   stall_timeout out sticky watchdog flag
// -----------------------------------------------------------------------------
module stall_watchdog #(
   parameter int STALL_LIMIT = 15
) (
   input  logic Clk,
   input  logic Rst,
   input  logic stall_applied,
   output logic stall_timeout
);

   localparam int            CW    = $clog2(STALL_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic          timeout_q;
   logic          timeout_d;

   // Next run length (saturating at the limit) and sticky flag update.
   always_comb begin
      count_d   = count_q;
      timeout_d = timeout_q;
      if (stall_applied) begin
         if (count_q != LIMIT) begin
            count_d = count_q + CW'(1);
         end else begin
            count_d = count_q;
         end
      end else begin
         count_d = '0;
      end
      // count_d can only equal LIMIT (>=1) on an applied-stall cycle.
      if (count_d == LIMIT) begin
         timeout_d = 1'b1;
      end else begin
         timeout_d = timeout_q;
      end
   end

   // Counter and flag registers.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         count_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         timeout_q <= timeout_d;
      end
   end

   assign stall_timeout = timeout_q;

endmodule : stall_watchdog

// File: rtl/pipeline_flow_controller.sv
// -----------------------------------------------------------------------------
// pipeline_flow_controller
// Front-end sequencer between decode and the PC, IF/ID and ID/EX registers.
// Turns EX busy, decode hazard and branch outcome into write enables, flush
// and bubble controls (same-cycle, combinational), runs a halt/drain sequence
// to quiesce the core, and hosts the stall watchdog.
//
// Ports:
//   Clk, Rst       clock (rising edge), asynchronous active-high reset
//   ID_stall       load-use/operand hazard from decode
//   ID_PCSrc       branch/jump taken in decode
//   EX_busy        multi-cycle EX unit not ready, freeze front end
//   halt_req       level request to quiesce the core
//   PC_Write       PC load enable
//   IF_ID_Write    IF/ID load enable
//   IF_ID_Flush    load NOP into IF/ID (meaningful with IF_ID_Write=1)
//   ID_EX_Write    ID/EX load enable
//   ID_EX_Bubble   zero control fields entering ID/EX
//   halted         core quiescent
//   stall_timeout  sticky watchdog flag
//
// Optional build macro FLOW_PERF_COUNTERS_EN adds:
//   stall_cycles[31:0]  cycles with a decode stall applied
//   flush_count[31:0]   branch-caused IF/ID flushes
// -----------------------------------------------------------------------------
module pipeline_flow_controller
   import pipeline_flow_controller_pkg::*;
#(
   parameter int STALL_LIMIT  = DEF_STALL_LIMIT,
   parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
   parameter bit DELAY_SLOT   = 1'b0
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        ID_stall,
   input  logic        ID_PCSrc,
   input  logic        EX_busy,
   input  logic        halt_req,
   output logic        PC_Write,
   output logic        IF_ID_Write,
   output logic        IF_ID_Flush,
   output logic        ID_EX_Write,
   output logic        ID_EX_Bubble,
   output logic        halted,
   output logic        stall_timeout
`ifdef FLOW_PERF_COUNTERS_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
`endif
);

   localparam int DC_W = $clog2(DRAIN_CYCLES + 1);

   flow_state_e   state_q;
   flow_state_e   state_d;
   logic [DC_W-1:0] drain_cnt_q;
   logic [DC_W-1:0] drain_cnt_d;

   logic pc_write_s;
   logic if_id_write_s;
   logic if_id_flush_s;
   logic id_ex_write_s;
   logic id_ex_bubble_s;
   logic halted_s;
   logic stall_applied_s;
   logic branch_flush_s;

   // Next-state and control decode; RUN evaluates busy > stall > branch > normal.
   always_comb begin
      state_d         = state_q;
      drain_cnt_d     = drain_cnt_q;
      pc_write_s      = 1'b0;
      if_id_write_s   = 1'b0;
      if_id_flush_s   = 1'b0;
      id_ex_write_s   = 1'b0;
      id_ex_bubble_s  = 1'b0;
      halted_s        = 1'b0;
      stall_applied_s = 1'b0;
      branch_flush_s  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (EX_busy) begin
               // Whole front end holds; defaults already say so.
               pc_write_s = 1'b0;
            end else if (ID_stall) begin
               // Operands invalid, so a concurrent branch outcome is ignored.
               id_ex_write_s   = 1'b1;
               id_ex_bubble_s  = 1'b1;
               stall_applied_s = 1'b1;
            end else if (ID_PCSrc) begin
               pc_write_s     = 1'b1;
               if_id_write_s  = 1'b1;
               id_ex_write_s  = 1'b1;
               if_id_flush_s  = ~DELAY_SLOT;
               branch_flush_s = ~DELAY_SLOT;
            end else if (halt_req) begin
               // ID instruction advances, fetched one is dropped and the PC
               // keeps pointing at it so RUN resumes there.
               if_id_write_s = 1'b1;
               if_id_flush_s = 1'b1;
               id_ex_write_s = 1'b1;
               state_d       = ST_DRAIN;
               drain_cnt_d   = DC_W'(DRAIN_CYCLES);
            end else begin
               pc_write_s    = 1'b1;
               if_id_write_s = 1'b1;
               id_ex_write_s = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (EX_busy) begin
               drain_cnt_d = drain_cnt_q;
            end else begin
               id_ex_write_s  = 1'b1;
               id_ex_bubble_s = 1'b1;
               if (drain_cnt_q <= DC_W'(1)) begin
                  state_d     = ST_HALT;
                  drain_cnt_d = '0;
               end else begin
                  drain_cnt_d = drain_cnt_q - DC_W'(1);
               end
            end
         end
         ST_HALT: begin
            halted_s = 1'b1;
            if (!halt_req) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_HALT;
            end
         end
         default: begin
            state_d     = ST_RUN;
            drain_cnt_d = '0;
         end
      endcase
   end

   // Sequencer state and drain counter.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q     <= ST_RUN;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   // Outputs are forced low for as long as Rst is asserted.
   assign PC_Write     = pc_write_s     & ~Rst;
   assign IF_ID_Write  = if_id_write_s  & ~Rst;
   assign IF_ID_Flush  = if_id_flush_s  & ~Rst;
   assign ID_EX_Write  = id_ex_write_s  & ~Rst;
   assign ID_EX_Bubble = id_ex_bubble_s & ~Rst;
   assign halted       = halted_s       & ~Rst;

   stall_watchdog #(
      .STALL_LIMIT (STALL_LIMIT)
   ) u_stall_watchdog (
      .Clk           (Clk),
      .Rst           (Rst),
      .stall_applied (stall_applied_s),
      .stall_timeout (stall_timeout)
   );

`ifdef FLOW_PERF_COUNTERS_EN
   logic [31:0] stall_cycles_q;
   logic [31:0] stall_cycles_d;
   logic [31:0] flush_count_q;
   logic [31:0] flush_count_d;

   // Free-running event counters, wrapping modulo 2^32.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (stall_applied_s) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end else begin
         stall_cycles_d = stall_cycles_q;
      end
      if (branch_flush_s) begin
         flush_count_d = flush_count_q + 32'd1;
      end else begin
         flush_count_d = flush_count_q;
      end
   end

   // Event counter registers.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         stall_cycles_q <= 32'd0;
         flush_count_q  <= 32'd0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`else
   logic perf_unused_s;
   assign perf_unused_s = branch_flush_s;
`endif

endmodule : pipeline_flow_controller
